// File: rtl/layer_compositor.sv
// Rectangle-layer compositor for the DVI path: double-buffered layer geometry, fixed-priority
// colour selection and per-frame collision flags, with syncs kept aligned to colour.
module layer_compositor #(
    parameter int unsigned NUM_LAYERS_P = 4,
    parameter int unsigned CORDW_P      = 10,
    parameter logic [11:0] BG_COLOR_P   = 12'h000
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              frame_i,
    input  logic [CORDW_P-1:0]                x_i,
    input  logic [CORDW_P-1:0]                y_i,
    input  logic                              hsync_i,
    input  logic                              vsync_i,
    input  logic                              de_i,
    input  logic [NUM_LAYERS_P*CORDW_P-1:0]   left_i,
    input  logic [NUM_LAYERS_P*CORDW_P-1:0]   right_i,
    input  logic [NUM_LAYERS_P*CORDW_P-1:0]   top_i,
    input  logic [NUM_LAYERS_P*CORDW_P-1:0]   bottom_i,
    input  logic [NUM_LAYERS_P*12-1:0]        color_i,
    input  logic [NUM_LAYERS_P-1:0]           enable_i,
    output logic                              hsync_o,
    output logic                              vsync_o,
    output logic                              de_o,
    output logic [3:0]                        r_o,
    output logic [3:0]                        g_o,
    output logic [3:0]                        b_o,
    output logic [NUM_LAYERS_P-1:0]           collision_o,
    output logic                              collision_valid_o
);

    localparam int unsigned N = NUM_LAYERS_P;
    localparam int unsigned W = CORDW_P;

    logic [W-1:0]  sh_left   [N];
    logic [W-1:0]  sh_right  [N];
    logic [W-1:0]  sh_top    [N];
    logic [W-1:0]  sh_bottom [N];
    logic [11:0]   sh_color  [N];
    logic [N-1:0]  sh_enable;

    logic [N-1:0]  hit;
    logic [11:0]   pick;
    logic [N-1:0]  hv;
    logic [11:0]   color1;
    logic          hsync1;
    logic          vsync1;
    logic          de1;
    logic [N-1:0]  acc;
    logic [N-1:0]  contrib;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sh_enable <= '0;
        end else if (frame_i) begin
            sh_enable <= enable_i;
        end
    end

    // Geometry and colour need no reset: the cleared enables keep every layer dark until reloaded.
    always_ff @(posedge clk_i) begin
        if (frame_i) begin
            for (int unsigned k = 0; k < N; k++) begin
                sh_left[k]   <= left_i[k*W +: W];
                sh_right[k]  <= right_i[k*W +: W];
                sh_top[k]    <= top_i[k*W +: W];
                sh_bottom[k] <= bottom_i[k*W +: W];
                sh_color[k]  <= color_i[k*12 +: 12];
            end
        end
    end

    always_comb begin
        hit = '0;
        for (int unsigned k = 0; k < N; k++) begin
            hit[k] = sh_enable[k]
                   && (x_i > sh_left[k]) && (x_i < sh_right[k])
                   && (y_i > sh_top[k])  && (y_i < sh_bottom[k]);
        end
    end

    // Colour is picked alongside the hit test so a strobe between stages cannot pair old hits with new colours.
    always_comb begin
        pick = BG_COLOR_P;
        for (int unsigned k = 0; k < N; k++) begin
            if (hit[N-1-k]) begin
                pick = sh_color[N-1-k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hv     <= '0;
            color1 <= '0;
            hsync1 <= 1'b0;
            vsync1 <= 1'b0;
            de1    <= 1'b0;
        end else begin
            hv     <= hit;
            color1 <= pick;
            hsync1 <= hsync_i;
            vsync1 <= vsync_i;
            de1    <= de_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hsync_o <= 1'b0;
            vsync_o <= 1'b0;
            de_o    <= 1'b0;
            r_o     <= '0;
            g_o     <= '0;
            b_o     <= '0;
        end else begin
            hsync_o           <= hsync1;
            vsync_o           <= vsync1;
            de_o              <= de1;
            {r_o, g_o, b_o}   <= de1 ? color1 : 12'h000;
        end
    end

    // Clearing the lowest set bit leaves a nonzero value only when two or more layers hit.
    assign contrib = (de1 && ((hv & (hv - N'(1))) != '0)) ? hv : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc               <= '0;
            collision_o       <= '0;
            collision_valid_o <= 1'b0;
        end else begin
            collision_valid_o <= frame_i;
            if (frame_i) begin
                collision_o <= acc | contrib;
                acc         <= '0;
            end else begin
                acc <= acc | contrib;
            end
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: a behavioural model queues expected pixels/syncs
// at drive time and they are compared when they emerge two cycles later.
module tb_layer_compositor;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 10;
    localparam logic [11:0] BG = 12'h123;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] rgb;
    } exp_t;

    logic            clk;
    logic            reset;
    logic            frame;
    logic [W-1:0]    x;
    logic [W-1:0]    y;
    logic            hsync;
    logic            vsync;
    logic            de;
    logic [N*W-1:0]  left;
    logic [N*W-1:0]  right;
    logic [N*W-1:0]  top;
    logic [N*W-1:0]  bottom;
    logic [N*12-1:0] color;
    logic [N-1:0]    enable;
    logic            hsync_q;
    logic            vsync_q;
    logic            de_q;
    logic [3:0]      r;
    logic [3:0]      g;
    logic [3:0]      b;
    logic [N-1:0]    collision;
    logic            collision_valid;

    int total = 0;
    int bad   = 0;

    exp_t         q[$];
    logic [W-1:0] m_l [N];
    logic [W-1:0] m_r [N];
    logic [W-1:0] m_t [N];
    logic [W-1:0] m_b [N];
    logic [11:0]  m_c [N];
    logic [N-1:0] m_en = '0;
    logic [N-1:0] s1_hv = '0;
    logic         s1_de = 1'b0;
    logic [N-1:0] m_acc = '0;
    logic [N-1:0] m_col = '0;
    logic         m_valid = 1'b0;
    logic         col_known = 1'b0;

    layer_compositor #(
        .NUM_LAYERS_P(N),
        .CORDW_P(W),
        .BG_COLOR_P(BG)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .frame_i(frame),
        .x_i(x),
        .y_i(y),
        .hsync_i(hsync),
        .vsync_i(vsync),
        .de_i(de),
        .left_i(left),
        .right_i(right),
        .top_i(top),
        .bottom_i(bottom),
        .color_i(color),
        .enable_i(enable),
        .hsync_o(hsync_q),
        .vsync_o(vsync_q),
        .de_o(de_q),
        .r_o(r),
        .g_o(g),
        .b_o(b),
        .collision_o(collision),
        .collision_valid_o(collision_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_layer(input int unsigned k, input logic [W-1:0] l, input logic [W-1:0] rr,
                             input logic [W-1:0] t, input logic [W-1:0] bb, input logic [11:0] c,
                             input logic en);
        left[k*W +: W]   = l;
        right[k*W +: W]  = rr;
        top[k*W +: W]    = t;
        bottom[k*W +: W] = bb;
        color[k*12 +: 12] = c;
        enable[k]        = en;
    endtask

    // One clock: check what is due now, then drive the next inputs and advance the model.
    task automatic step(input logic [W-1:0] xx, input logic [W-1:0] yy, input logic hs,
                        input logic vs, input logic d, input logic fr, input logic rs);
        exp_t         e;
        exp_t         h;
        logic [N-1:0] hv;
        logic [N-1:0] con;
        logic         found;
        @(posedge clk);
        #1;
        if (q.size() == 2) begin
            h = q.pop_front();
            check("hsync", 32'(hsync_q), 32'(h.hs));
            check("vsync", 32'(vsync_q), 32'(h.vs));
            check("de", 32'(de_q), 32'(h.de));
            check("rgb", 32'({r, g, b}), 32'(h.rgb));
        end
        if (col_known) begin
            check("coll_valid", 32'(collision_valid), 32'(m_valid));
            check("collision", 32'(collision), 32'(m_col));
        end

        x = xx; y = yy; hsync = hs; vsync = vs; de = d; frame = fr; reset = rs;

        hv = '0;
        for (int k = 0; k < N; k++) begin
            hv[k] = m_en[k] && (xx > m_l[k]) && (xx < m_r[k]) && (yy > m_t[k]) && (yy < m_b[k]);
        end
        e.hs = hs; e.vs = vs; e.de = d; e.rgb = 12'h000;
        if (d) begin
            e.rgb = BG;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && hv[k]) begin
                    e.rgb = m_c[k];
                    found = 1'b1;
                end
            end
        end

        if (rs) begin
            foreach (q[i]) q[i] = '0;
            q.push_back('0);
            m_en = '0; m_acc = '0; m_col = '0; m_valid = 1'b0;
            s1_hv = '0; s1_de = 1'b0;
        end else begin
            q.push_back(e);
            con = (s1_de && $countones(s1_hv) >= 2) ? s1_hv : '0;
            if (fr) begin
                m_col = m_acc | con;
                m_acc = '0;
            end else begin
                m_acc = m_acc | con;
            end
            m_valid = fr;
            s1_hv = hv;
            s1_de = d;
            if (fr) begin
                for (int k = 0; k < N; k++) begin
                    m_l[k] = left[k*W +: W];
                    m_r[k] = right[k*W +: W];
                    m_t[k] = top[k*W +: W];
                    m_b[k] = bottom[k*W +: W];
                    m_c[k] = color[k*12 +: 12];
                end
                m_en = enable;
            end
        end
        col_known = 1'b1;
    endtask

    task automatic strobe();
        step(10'd2, 10'd481, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(10'd3, 10'd481, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        for (int yy = y0; yy <= y1; yy++) begin
            for (int xx = x0; xx <= x1; xx++) begin
                step(W'(xx), W'(yy), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        reset = 1'b1; frame = 1'b0; x = '0; y = '0; hsync = 1'b0; vsync = 1'b0; de = 1'b0;
        left = '0; right = '0; top = '0; bottom = '0; color = '0; enable = '0;
        for (int k = 0; k < N; k++) begin
            m_l[k] = '0; m_r[k] = '0; m_t[k] = '0; m_b[k] = '0; m_c[k] = '0;
        end
        repeat (3) step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Latency and alignment with random syncs, nothing enabled yet.
        for (int i = 0; i < 60; i++) begin
            step(W'($urandom_range(0, 639)), W'($urandom_range(0, 479)),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        end

        // Single layer with exclusive bounds.
        set_layer(0, 10'd100, 10'd120, 10'd399, 10'd414, 12'h5E5, 1'b1);
        strobe();
        scan(98, 122, 398, 415);

        // Priority: blue L0 over red L1, then L0 disabled.
        set_layer(0, 10'd140, 10'd161, 10'd10, 10'd20, 12'h00F, 1'b1);
        set_layer(1, 10'd149, 10'd171, 10'd10, 10'd20, 12'hF00, 1'b1);
        strobe();
        scan(138, 173, 15, 15);
        enable[0] = 1'b0;
        strobe();
        scan(138, 173, 15, 15);

        // Tear-free: geometry change mid-frame is invisible until the next strobe.
        set_layer(1, 10'd0, 10'd0, 10'd0, 10'd0, 12'h000, 1'b0);
        set_layer(0, 10'd300, 10'd320, 10'd190, 10'd210, 12'h0F0, 1'b1);
        strobe();
        scan(295, 325, 199, 199);
        left[0 +: W] = 10'd310;
        scan(295, 325, 200, 201);
        strobe();
        scan(295, 325, 200, 200);

        // Collision: L1 overlaps L2, L0 isolated.
        set_layer(0, 10'd10, 10'd20, 10'd300, 10'd310, 12'hAAA, 1'b1);
        set_layer(1, 10'd400, 10'd420, 10'd50, 10'd60, 12'h0F0, 1'b1);
        set_layer(2, 10'd410, 10'd430, 10'd50, 10'd60, 12'hF0F, 1'b1);
        strobe();
        scan(395, 435, 55, 55);
        scan(8, 22, 305, 305);
        strobe();
        check("coll_6", 32'(collision), 32'h6);
        set_layer(2, 10'd500, 10'd520, 10'd50, 10'd60, 12'hF0F, 1'b1);
        scan(395, 435, 55, 55);
        strobe();
        scan(395, 525, 55, 55);
        strobe();
        check("coll_0", 32'(collision), 32'h0);

        // Reset mid-frame, then layers return after the next strobe.
        set_layer(1, 10'd0, 10'd0, 10'd0, 10'd0, 12'h000, 1'b0);
        set_layer(2, 10'd0, 10'd0, 10'd0, 10'd0, 12'h000, 1'b0);
        set_layer(0, 10'd50, 10'd70, 10'd230, 10'd250, 12'h3C3, 1'b1);
        strobe();
        scan(45, 58, 240, 240);
        step(10'd59, 10'd240, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        scan(60, 75, 240, 240);
        strobe();
        scan(45, 75, 240, 240);

        repeat (3) step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
